// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - read, write and scoreboard signal bundle for reg_file_sb
interface reg_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int N_RD   = 2
);
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_RD-1:0]        rd_busy;
  logic                   wr0_en;
  logic [ADDR_W-1:0]      wr0_addr;
  logic [DATA_W/8-1:0]    wr0_be;
  logic [DATA_W-1:0]      wr0_data;
  logic                   wr0_clr;
  logic                   wr1_en;
  logic [ADDR_W-1:0]      wr1_addr;
  logic [DATA_W/8-1:0]    wr1_be;
  logic [DATA_W-1:0]      wr1_data;
  logic                   wr1_clr;
  logic                   sb_set_en;
  logic [ADDR_W-1:0]      sb_set_addr;
  logic                   sb_flush;
  logic [ADDR_W:0]        busy_cnt;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_be, wr0_data, wr0_clr,
    output wr1_en, wr1_addr, wr1_be, wr1_data, wr1_clr,
    output sb_set_en, sb_set_addr, sb_flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_be, wr0_data, wr0_clr,
    input  wr1_en, wr1_addr, wr1_be, wr1_data, wr1_clr,
    input  sb_set_en, sb_set_addr, sb_flush,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-read, dual-write register file with busy-bit scoreboard
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int N_RD     = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input logic          clk_i,
  input logic          rst_i,
  reg_file_sb_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic wr0_ok, wr1_ok, set_ok;
  logic [N_RD*DATA_W-1:0] rd_data_c;
  logic [N_RD-1:0]        rd_busy_c;
  logic [ADDR_W-1:0]      ra;
  logic [DATA_W-1:0]      rv;
  logic                   rb;

  // Accesses to the hardwired-zero register are squashed here, once, for every consumer.
  assign wr0_ok = rf.wr0_en && !((ZERO_REG != 0) && (rf.wr0_addr == '0));
  assign wr1_ok = rf.wr1_en && !((ZERO_REG != 0) && (rf.wr1_addr == '0));
  assign set_ok = rf.sb_set_en && !((ZERO_REG != 0) && (rf.sb_set_addr == '0));

  always_comb begin
    regs_d = regs_q;
    for (int b = 0; b < NB; b++) begin
      if (wr0_ok && rf.wr0_be[b]) regs_d[rf.wr0_addr][8*b +: 8] = rf.wr0_data[8*b +: 8];
      if (wr1_ok && rf.wr1_be[b]) regs_d[rf.wr1_addr][8*b +: 8] = rf.wr1_data[8*b +: 8];
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (rf.sb_flush) begin
      busy_d = '0;
    end else begin
      if (wr0_ok && rf.wr0_clr) busy_d[rf.wr0_addr] = 1'b0;
      if (wr1_ok && rf.wr1_clr) busy_d[rf.wr1_addr] = 1'b0;
      if (set_ok) busy_d[rf.sb_set_addr] = 1'b1;
    end
    cnt_d = '0;
    for (int k = 0; k < DEPTH; k++) cnt_d = cnt_d + CNT_W'(busy_d[k]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Bypass merges in this cycle's writes and clears, but never sets or flushes.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    ra = '0;
    rv = '0;
    rb = 1'b0;
    for (int i = 0; i < N_RD; i++) begin
      ra = rf.rd_addr[i*ADDR_W +: ADDR_W];
      rv = regs_q[ra];
      rb = busy_q[ra];
      if (BYPASS != 0) begin
        for (int b = 0; b < NB; b++) begin
          if (wr0_ok && rf.wr0_be[b] && rf.wr0_addr == ra) rv[8*b +: 8] = rf.wr0_data[8*b +: 8];
          if (wr1_ok && rf.wr1_be[b] && rf.wr1_addr == ra) rv[8*b +: 8] = rf.wr1_data[8*b +: 8];
        end
        if (wr0_ok && rf.wr0_clr && rf.wr0_addr == ra) rb = 1'b0;
        if (wr1_ok && rf.wr1_clr && rf.wr1_addr == ra) rb = 1'b0;
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rv = '0;
        rb = 1'b0;
      end
      rd_data_c[i*DATA_W +: DATA_W] = rv;
      rd_busy_c[i] = rb;
    end
  end

  assign rf.rd_data  = rd_data_c;
  assign rf.rd_busy  = rd_busy_c;
  assign rf.busy_cnt = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed scoreboard bench over bypass, no-bypass and zero-register builds
module tb_reg_file_sb;
  localparam int D0 = 0, D1 = 1, B0 = 2, B1 = 3, CN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0]  rd_addr = '0;
  logic        wr0_en = 0, wr0_clr = 0, wr1_en = 0, wr1_clr = 0;
  logic [2:0]  wr0_addr = '0, wr1_addr = '0, sb_set_addr = '0;
  logic [1:0]  wr0_be = '0, wr1_be = '0;
  logic [15:0] wr0_data = '0, wr1_data = '0;
  logic        sb_set_en = 0, sb_flush = 0;

  typedef struct {
    int          dut;
    int          kind;
    logic [15:0] exp;
    string       tag;
  } exp_t;
  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(16), .ADDR_W(3), .N_RD(2)) if_a ();
  reg_file_sb_if #(.DATA_W(16), .ADDR_W(3), .N_RD(2)) if_b ();
  reg_file_sb_if #(.DATA_W(16), .ADDR_W(3), .N_RD(2)) if_z ();

`define TB_DRIVE(IFN) \
  assign IFN.rd_addr = rd_addr; assign IFN.wr0_en = wr0_en; assign IFN.wr0_addr = wr0_addr; \
  assign IFN.wr0_be = wr0_be; assign IFN.wr0_data = wr0_data; assign IFN.wr0_clr = wr0_clr; \
  assign IFN.wr1_en = wr1_en; assign IFN.wr1_addr = wr1_addr; assign IFN.wr1_be = wr1_be; \
  assign IFN.wr1_data = wr1_data; assign IFN.wr1_clr = wr1_clr; assign IFN.sb_set_en = sb_set_en; \
  assign IFN.sb_set_addr = sb_set_addr; assign IFN.sb_flush = sb_flush;

  `TB_DRIVE(if_a)
  `TB_DRIVE(if_b)
  `TB_DRIVE(if_z)

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .N_RD(2), .BYPASS(1), .ZERO_REG(0))
    dut_a (.clk_i(clk), .rst_i(rst), .rf(if_a.slave));
  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .N_RD(2), .BYPASS(0), .ZERO_REG(0))
    dut_b (.clk_i(clk), .rst_i(rst), .rf(if_b.slave));
  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .N_RD(2), .BYPASS(1), .ZERO_REG(1))
    dut_z (.clk_i(clk), .rst_i(rst), .rf(if_z.slave));

  function automatic logic [15:0] pick(logic [31:0] rdat, logic [1:0] rbsy, logic [3:0] cnt, int kind);
    case (kind)
      D0:      return rdat[15:0];
      D1:      return rdat[31:16];
      B0:      return {15'd0, rbsy[0]};
      B1:      return {15'd0, rbsy[1]};
      default: return {12'd0, cnt};
    endcase
  endfunction

  function automatic logic [15:0] observe(int d, int kind);
    case (d)
      0:       return pick(if_a.rd_data, if_a.rd_busy, if_a.busy_cnt, kind);
      1:       return pick(if_b.rd_data, if_b.rd_busy, if_b.busy_cnt, kind);
      default: return pick(if_z.rd_data, if_z.rd_busy, if_z.busy_cnt, kind);
    endcase
  endfunction

  task automatic ex(int d, int kind, logic [15:0] v, string t);
    exp_t e;
    e.dut = d; e.kind = kind; e.exp = v; e.tag = t;
    sbq.push_back(e);
  endtask

  task automatic ex3(int kind, logic [15:0] v, string t);
    for (int d = 0; d < 3; d++) ex(d, kind, v, t);
  endtask

  // Compare everything queued for this cycle mid-cycle, then advance one edge.
  task automatic cyc();
    exp_t e;
    logic [15:0] o;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = observe(e.dut, e.kind);
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $error("FAIL %s dut%0d observed=%h expected=%h", e.tag, e.dut, o, e.exp);
      end
    end
    @(posedge clk);
    #1;
    wr0_en = 0; wr0_clr = 0; wr1_en = 0; wr1_clr = 0;
    sb_set_en = 0; sb_flush = 0;
  endtask

  task automatic w0(logic [2:0] a, logic [1:0] be, logic [15:0] d, logic clr);
    wr0_en = 1; wr0_addr = a; wr0_be = be; wr0_data = d; wr0_clr = clr;
  endtask

  task automatic w1(logic [2:0] a, logic [1:0] be, logic [15:0] d, logic clr);
    wr1_en = 1; wr1_addr = a; wr1_be = be; wr1_data = d; wr1_clr = clr;
  endtask

  task automatic sset(logic [2:0] a);
    sb_set_en = 1; sb_set_addr = a;
  endtask

  initial begin
    cyc();
    rst = 0;
    rd_addr = {3'd4, 3'd3};
    ex3(D0, 16'h0000, "reset_data"); ex3(B0, 16'h0, "reset_busy"); ex3(CN, 16'h0, "reset_cnt");
    cyc();

    w0(3'd3, 2'b11, 16'hBEEF, 0);
    ex(0, D0, 16'hBEEF, "wr_bypass"); ex(1, D0, 16'h0000, "wr_nobypass"); ex(2, D0, 16'hBEEF, "wr_bypass");
    cyc();
    ex3(D0, 16'hBEEF, "rd_r3"); ex3(D1, 16'h0000, "rd_r4");
    cyc();

    rst = 1; w0(3'd3, 2'b11, 16'h1111, 0); sset(3'd3);
    cyc();
    rst = 0;
    ex3(D0, 16'h0000, "midrst_data"); ex3(B0, 16'h0, "midrst_busy"); ex3(CN, 16'h0, "midrst_cnt");
    cyc();

    rd_addr = {3'd4, 3'd5};
    w0(3'd5, 2'b11, 16'h1234, 0);
    cyc();
    w0(3'd5, 2'b11, 16'hAAAA, 0); w1(3'd5, 2'b01, 16'h55CC, 0);
    ex(0, D0, 16'hAACC, "coll_bypass"); ex(1, D0, 16'h1234, "coll_nobypass"); ex(2, D0, 16'hAACC, "coll_bypass");
    cyc();
    ex3(D0, 16'hAACC, "coll_result");
    cyc();

    rd_addr = {3'd4, 3'd2};
    sset(3'd2);
    cyc();
    w0(3'd2, 2'b01, 16'h00FF, 1);
    ex(0, D0, 16'h00FF, "byp_data"); ex(0, B0, 16'h0, "byp_busy");
    ex(1, D0, 16'h0000, "nobyp_data"); ex(1, B0, 16'h1, "nobyp_busy");
    ex(2, D0, 16'h00FF, "byp_data"); ex(2, B0, 16'h0, "byp_busy");
    ex3(CN, 16'd1, "byp_cnt");
    cyc();
    ex3(D0, 16'h00FF, "after_byp_data"); ex3(B0, 16'h0, "after_byp_busy"); ex3(CN, 16'd0, "after_byp_cnt");
    cyc();

    rd_addr = {3'd4, 3'd6};
    sset(3'd1);
    cyc();
    sset(3'd6); ex3(CN, 16'd1, "sb_cnt1");
    cyc();
    sset(3'd7); ex3(CN, 16'd2, "sb_cnt2");
    cyc();
    sset(3'd6); w1(3'd6, 2'b00, 16'hFFFF, 1);
    ex3(CN, 16'd3, "sb_cnt3");
    ex(0, B0, 16'h0, "setclr_byp_busy"); ex(1, B0, 16'h1, "setclr_nobyp_busy"); ex(2, B0, 16'h0, "setclr_byp_busy");
    cyc();
    ex3(CN, 16'd3, "set_wins_cnt"); ex3(B0, 16'h1, "set_wins_busy"); ex3(D0, 16'h0000, "be0_nochange");
    cyc();
    rd_addr = {3'd4, 3'd1};
    w0(3'd1, 2'b00, 16'h0000, 1);
    cyc();
    sb_flush = 1; sset(3'd4);
    ex3(CN, 16'd2, "clr_r1_cnt"); ex3(B0, 16'h0, "clr_r1_busy");
    cyc();
    rd_addr = {3'd4, 3'd4};
    ex3(CN, 16'd0, "flush_cnt"); ex3(B0, 16'h0, "flush_r4_busy");
    cyc();

    rd_addr = {3'd7, 3'd0};
    w0(3'd0, 2'b11, 16'hFFFF, 0); sset(3'd0);
    ex(0, D0, 16'hFFFF, "r0_byp"); ex(1, D0, 16'h0000, "r0_nobyp"); ex(2, D0, 16'h0000, "zero_r0_data");
    ex3(B0, 16'h0, "r0_busy_now");
    cyc();
    ex(0, D0, 16'hFFFF, "r0_data"); ex(1, D0, 16'hFFFF, "r0_data"); ex(2, D0, 16'h0000, "zero_r0_data");
    ex(0, B0, 16'h1, "r0_busy"); ex(1, B0, 16'h1, "r0_busy"); ex(2, B0, 16'h0, "zero_r0_busy");
    ex(0, CN, 16'd1, "r0_cnt"); ex(1, CN, 16'd1, "r0_cnt"); ex(2, CN, 16'd0, "zero_r0_cnt");
    cyc();
    for (int r = 0; r < 8; r++) begin
      sset(3'(r));
      cyc();
    end
    ex(0, CN, 16'd8, "full_cnt"); ex(1, CN, 16'd8, "full_cnt"); ex(2, CN, 16'd7, "zero_full_cnt");
    ex3(B1, 16'h1, "full_r7_busy");
    ex(0, B0, 16'h1, "full_r0_busy"); ex(1, B0, 16'h1, "full_r0_busy"); ex(2, B0, 16'h0, "zero_full_r0_busy");
    sb_flush = 1;
    cyc();
    ex3(CN, 16'd0, "final_flush_cnt"); ex3(B1, 16'h0, "final_flush_busy");
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
